uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Serializes TPU response frames onto the Basys3 `uart_tx` pin as 8N1 UART. It is the transmit-side counterpart of the TPU's UART command receiver. On `start` it emits a fixed header, streams a payload fetched byte-by-byte from a synchronous read port (unified buffer or result buffer), then appends an XOR checksum. It sits inside `tpu_top` between the result/UB read mux and the `uart_tx` output.

## Interface
- `CLKS_PER_BIT`, default 868; clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `SYNC_BYTE`, default 8'hA5; first byte of every frame.
- `clk  in  1`: system clock; all state is on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: frame request; sampled only in IDLE.
- `cmd  in  8`: command/status byte echoed in the header; latched on accepted `start`.
- `len  in  16`: payload byte count N (0..65535); latched on accepted `start`.
- `rd_en  out  1`: payload read strobe, one cycle per payload byte.
- `rd_addr  out  16`: payload byte index, 0..N-1; valid while `rd_en`=1.
- `rd_data  in  8`: payload byte; valid exactly one cycle after `rd_en`.
- `uart_tx  out  1`: serial line, idle high.
- `busy  out  1`: high from the cycle after an accepted `start` until `done`.
- `done  out  1`: one-cycle pulse at frame end.
- `debug_state  out  4`: current FSM state code.

## Operation
- Frame byte order: SYNC_BYTE, cmd, len[15:8], len[7:0], payload[0..N-1], chk.
- chk = cmd ^ len[15:8] ^ len[7:0] ^ payload[0] ^ … ^ payload[N-1]. SYNC_BYTE is excluded. With N=0, chk = cmd ^ len_hi ^ len_lo.
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states and `debug_state` codes: IDLE=0, SHIFT=1, FETCH=2, WAIT=3, DONE=4.
  - IDLE: line high. `start`=1 latches cmd/len, loads SYNC_BYTE, clears the checksum, and goes to SHIFT.
  - SHIFT: serializes the loaded byte. On completion of its stop bit:
    - if the next byte is a header byte or chk, load it and stay in SHIFT (no gap);
    - if the next byte is payload, go to FETCH;
    - after chk, go to DONE.
  - FETCH: one cycle with `rd_en`=1 and `rd_addr`=payload index; line high.
  - WAIT: one cycle; `rd_data` is captured at the end of the cycle and XORed into the checksum, then go to SHIFT.
  - DONE: one cycle with `done`=1 and `busy`=0, then go to IDLE.
- `start` while not in IDLE is ignored. It is not queued.
- Checksum is accumulated over an 8-bit register. The payload index counter is 16 bits and never wraps within a frame.
- `uart_tx` is driven from a register and is glitch-free.

## Timing
- Reset values:
  - `uart_tx`=1
  - `busy`=0
  - `done`=0
  - `rd_en`=0
  - `rd_addr`=0
  - `debug_state`=0
- `start` accepted at cycle 0:
  - `busy`=1 and `uart_tx`=0 (SYNC start bit) from cycle 1.
  - Header bytes are back-to-back, 10·CLKS_PER_BIT cycles each.
  - Each payload byte is preceded by exactly 2 idle-high cycles (FETCH, WAIT).
  - `done` is asserted at cycle 1 + (5+N)·10·CLKS_PER_BIT + 2N.
- `rd_en` never asserts for N=0. There are exactly N `rd_en` pulses per frame, with addresses strictly incrementing from 0.
- A `start` in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after `done`.
- Reset mid-frame:
  - All outputs return to reset values asynchronously.
  - The partial frame is abandoned and no `done` pulse is produced.
  - After reset release, the FSM is in IDLE with the line high.

## Test plan
- **Basic frame.** CLKS_PER_BIT=4, start with cmd=8'h12, len=2, memory {8'h34, 8'h56}.
  - Decoded line bytes: A5, 12, 00, 02, 34, 56, 72.
  - `done` at cycle 1+7·40+4=285.
  - `rd_addr` pulses 0 then 1.
- **Empty payload.** cmd=8'hFF, len=0.
  - Bytes: A5, FF, 00, 00, FF.
  - No `rd_en`.
  - `done` at cycle 201.
  - `busy` high cycles 1..200.
- **Start while busy.** Pulse `start` at cycles 50 and 100 during frame 1.
  - Exactly one frame is sent.
  - Then assert `start` the cycle after `done`: a second frame begins, with its start bit on the following cycle.
- **Bit timing.** CLKS_PER_BIT=868, cmd=8'h55.
  - Every line transition lands on a multiple of 868 cycles from cycle 1.
  - The stop bit is high for 868 cycles.
- **Reset mid-payload.** Assert `rst_n`=0 during payload byte 1.
  - `uart_tx`=1, `busy`=0, `rd_en`=0 immediately.
  - No `done` pulse.
  - A fresh frame after release is byte-exact.
- **Long payload.** len=300, memory[i]=i[7:0].
  - 300 sequential reads.
  - Checksum equals XOR of the header fields and all payload bytes.
  - Index does not wrap at 256.

Source files
------------

// File: rtl/uart_frame_tx.sv
// 8N1 UART frame transmitter: SYNC, cmd, len_hi, len_lo, payload[0..N-1], XOR checksum.
// Payload bytes are fetched one at a time from a synchronous read port with 1-cycle latency.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] len,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  debug_state
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StShift = 4'd1,
    StFetch = 4'd2,
    StWait  = 4'd3,
    StDone  = 4'd4
  } state_e;

  // Which byte of the frame is currently loaded in the shifter.
  typedef enum logic [2:0] {
    PhSync,
    PhCmd,
    PhLenHi,
    PhLenLo,
    PhPayload,
    PhChk
  } phase_e;

  state_e          state_q;
  phase_e          phase_q;
  logic [7:0]      cmd_q;
  logic [15:0]     len_q;
  logic [7:0]      shift_q;
  logic [7:0]      chk_q;
  logic [15:0]     idx_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [3:0]      bit_idx_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  logic [15:0]     rd_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_q   <= PhSync;
      cmd_q     <= 8'h00;
      len_q     <= 16'h0000;
      shift_q   <= 8'h00;
      chk_q     <= 8'h00;
      idx_q     <= 16'h0000;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'h0000;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cmd_q     <= cmd;
            len_q     <= len;
            shift_q   <= SYNC_BYTE;
            chk_q     <= 8'h00;
            idx_q     <= 16'h0000;
            phase_q   <= PhSync;
            clk_cnt_q <= '0;
            bit_idx_q <= 4'd0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (clk_cnt_q != CntMax) begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end else begin
            clk_cnt_q <= '0;
            if (bit_idx_q != 4'd9) begin
              // Advance to the next bit: data LSB first, then the stop bit.
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : shift_q[bit_idx_q[2:0]];
            end else begin
              bit_idx_q <= 4'd0;
              unique case (phase_q)
                PhSync: begin
                  shift_q <= cmd_q;
                  chk_q   <= chk_q ^ cmd_q;
                  phase_q <= PhCmd;
                  tx_q    <= 1'b0;
                end
                PhCmd: begin
                  shift_q <= len_q[15:8];
                  chk_q   <= chk_q ^ len_q[15:8];
                  phase_q <= PhLenHi;
                  tx_q    <= 1'b0;
                end
                PhLenHi: begin
                  shift_q <= len_q[7:0];
                  chk_q   <= chk_q ^ len_q[7:0];
                  phase_q <= PhLenLo;
                  tx_q    <= 1'b0;
                end
                PhLenLo, PhPayload: begin
                  if (idx_q == len_q) begin
                    shift_q <= chk_q;
                    phase_q <= PhChk;
                    tx_q    <= 1'b0;
                  end else begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= idx_q;
                    phase_q   <= PhPayload;
                    state_q   <= StFetch;
                  end
                end
                PhChk: begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
                end
                default: state_q <= StIdle;
              endcase
            end
          end
        end
        StFetch: state_q <= StWait;
        StWait: begin
          // Read data arrives the cycle after the strobe; start bit begins immediately.
          shift_q <= rd_data;
          chk_q   <= chk_q ^ rd_data;
          idx_q   <= idx_q + 16'd1;
          tx_q    <= 1'b0;
          state_q <= StShift;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx     = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: per-cycle waveform model built from the frame rules,
// plus an independent UART receiver decoding the observed line.
module tb_uart_frame_tx;

  localparam int Cpb     = 4;
  localparam int SlowCpb = 868;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd   = 8'h00;
  logic [15:0] len   = 16'h0000;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        uart_tx, busy, done;
  logic [3:0]  debug_state;

  logic        start_s = 1'b0;
  logic [7:0]  cmd_s   = 8'h00;
  logic [15:0] len_s   = 16'h0000;
  logic [7:0]  rd_data_s = 8'h00;
  logic        rd_en_s, uart_tx_s, busy_s, done_s;
  logic [15:0] rd_addr_s;
  logic [3:0]  debug_state_s;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLKS_PER_BIT(Cpb), .SYNC_BYTE(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .uart_tx(uart_tx), .busy(busy), .done(done), .debug_state(debug_state)
  );

  uart_frame_tx #(.CLKS_PER_BIT(SlowCpb), .SYNC_BYTE(8'hA5)) u_dut_slow (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cmd(cmd_s), .len(len_s),
    .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .uart_tx(uart_tx_s), .busy(busy_s), .done(done_s), .debug_state(debug_state_s)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_bytes[$];
  logic [7:0] dec_bytes[$];
  bit         exp_tx[$];
  logic [3:0] exp_st[$];
  bit         obs_tx[$];

  // Memory responder: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_expected(input int cpb, input logic [7:0] c, input logic [15:0] n);
    logic [7:0] chk;
    logic [7:0] by;
    bit         lvl;
    exp_bytes.delete();
    exp_tx.delete();
    exp_st.delete();
    chk = c ^ n[15:8] ^ n[7:0];
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(c);
    exp_bytes.push_back(n[15:8]);
    exp_bytes.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      exp_bytes.push_back(mem[i]);
      chk = chk ^ mem[i];
    end
    exp_bytes.push_back(chk);
    for (int j = 0; j < int'(exp_bytes.size()); j++) begin
      by = exp_bytes[j];
      if (j >= 4 && j < 4 + int'(n)) begin
        exp_tx.push_back(1'b1); exp_st.push_back(4'd2);
        exp_tx.push_back(1'b1); exp_st.push_back(4'd3);
      end
      for (int b = 0; b < 10; b++) begin
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : by[b-1];
        for (int r = 0; r < cpb; r++) begin
          exp_tx.push_back(lvl);
          exp_st.push_back(4'd1);
        end
      end
    end
  endfunction

  // Plain UART receiver: find start bit, sample each bit at its centre.
  function automatic void decode(input int cpb);
    int i;
    logic [7:0] b;
    dec_bytes.delete();
    i = 0;
    while (i + 10 * cpb <= int'(obs_tx.size())) begin
      if (obs_tx[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = obs_tx[i + (k + 1) * cpb + cpb / 2];
        dec_bytes.push_back(b);
        i = i + 9 * cpb + cpb / 2;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic reset_mid_frame();
    int done_seen = 0;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_eq("rst_mid_tx", uart_tx, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_rd_en", rd_en, 0);
    check_eq("rst_mid_rd_addr", rd_addr, 0);
    check_eq("rst_mid_state", debug_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || uart_tx !== 1'b1 || debug_state !== 4'd0) done_seen++;
    end
    check_eq("rst_release_idle_no_done", done_seen, 0);
  endtask

  // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_frame(input string name, input logic [7:0] c, input logic [15:0] n,
                           input int pulse_a, input int pulse_b, input int abort_at,
                           input bit chain);
    int t;
    int line_bad = 0, st_bad = 0, rd_bad = 0, busy_bad = 0, done_bad = 0;
    int addr_bad = 0, pulses = 0, nb;
    build_expected(Cpb, c, n);
    t = exp_tx.size();
    obs_tx.delete();
    start = 1'b1;
    cmd   = c;
    len   = n;
    @(posedge clk);
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      start = (k == pulse_a || k == pulse_b);
      cmd   = 8'($urandom);
      len   = 16'($urandom);
      if (k == abort_at) begin
        reset_mid_frame();
        return;
      end
      if (k <= t) begin
        obs_tx.push_back(uart_tx);
        if (uart_tx !== exp_tx[k-1]) line_bad++;
        if (debug_state !== exp_st[k-1]) st_bad++;
        if (rd_en !== (exp_st[k-1] == 4'd2)) rd_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (done !== 1'b0) done_bad++;
        if (rd_en === 1'b1) begin
          if (rd_addr !== 16'(pulses)) addr_bad++;
          pulses++;
        end
      end else begin
        check_eq({name, "_done_at_end"}, done, 1);
        check_eq({name, "_busy_at_done"}, busy, 0);
        check_eq({name, "_tx_at_done"}, uart_tx, 1);
        check_eq({name, "_state_done"}, debug_state, 4);
        start = chain;
      end
    end
    check_eq({name, "_line_bad_cycles"}, line_bad, 0);
    check_eq({name, "_state_bad_cycles"}, st_bad, 0);
    check_eq({name, "_rd_en_bad_cycles"}, rd_bad, 0);
    check_eq({name, "_busy_bad_cycles"}, busy_bad, 0);
    check_eq({name, "_early_done_cycles"}, done_bad, 0);
    check_eq({name, "_rd_pulses"}, pulses, 32'(n));
    check_eq({name, "_rd_addr_bad"}, addr_bad, 0);
    decode(Cpb);
    check_eq({name, "_byte_count"}, dec_bytes.size(), exp_bytes.size());
    nb = (dec_bytes.size() < exp_bytes.size()) ? dec_bytes.size() : exp_bytes.size();
    for (int j = 0; j < nb; j++)
      check_eq($sformatf("%s_byte%0d", name, j), dec_bytes[j], exp_bytes[j]);
    @(negedge clk);
    // A start held through the done cycle must not have been taken there.
    check_eq({name, "_idle_busy"}, busy, 0);
    check_eq({name, "_idle_tx"}, uart_tx, 1);
    check_eq({name, "_idle_state"}, debug_state, 0);
  endtask

  task automatic run_slow();
    int t, line_bad = 0, off_grid = 0;
    bit prev = 1'b1;
    build_expected(SlowCpb, 8'h55, 16'd0);
    t = exp_tx.size();
    start_s = 1'b1;
    cmd_s   = 8'h55;
    len_s   = 16'd0;
    @(posedge clk);
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (k <= t) begin
        if (uart_tx_s !== exp_tx[k-1]) line_bad++;
        if (uart_tx_s !== prev && ((k - 1) % SlowCpb) != 0) off_grid++;
        prev = uart_tx_s;
      end else begin
        check_eq("slow_done", done_s, 1);
      end
    end
    check_eq("slow_line_bad_cycles", line_bad, 0);
    check_eq("slow_off_grid_edges", off_grid, 0);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [15:0] rn;
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_tx", uart_tx, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rd_en", rd_en, 0);
    check_eq("reset_rd_addr", rd_addr, 0);
    check_eq("reset_state", debug_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mem[0] = 8'h34;
    mem[1] = 8'h56;
    run_frame("basic", 8'h12, 16'd2, 0, 0, 0, 1'b0);
    check_eq("basic_chk_byte", dec_bytes[6], 8'h72);

    run_frame("empty", 8'hFF, 16'd0, 0, 0, 0, 1'b0);
    check_eq("empty_chk_byte", dec_bytes[4], 8'hFF);

    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    run_frame("busy_start", 8'($urandom), 16'd3, 50, 100, 0, 1'b1);
    run_frame("restart", 8'h3C, 16'd1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 300; i++) mem[i] = 8'(i);
    run_frame("long", 8'h81, 16'd300, 0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    run_frame("abort", 8'h9A, 16'd4, 0, 0, 220, 1'b0);
    run_frame("after_rst", 8'h9A, 16'd4, 0, 0, 0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      rc = 8'($urandom);
      rn = 16'($urandom_range(0, 24));
      for (int i = 0; i < int'(rn); i++) mem[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", f), rc, rn, 0, 0, 0, 1'b0);
    end

    run_slow();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
